// File: rtl/irf_writeback.sv
`default_nettype none
// ============================================================================
// Module   : irf_writeback
// Purpose  : Write side of the integer register file. Merges ALU results and
//            queued load results onto the single RF write port and keeps a
//            per-register pending scoreboard for RAW/WAW stalls at issue.
//            R31 is hard-wired zero and is never written or tracked.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   LDQ_DEPTH  load-result queue entries (power of two, >= 2)
//   DATA_BITS  result width
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   issue_valid/issue_dest     destination leaving the read stage
//   issue_stall                comb, destination still has a write outstanding
//   alu_valid/alu_dest/alu_data   ALU result, always accepted
//   ld_valid/ld_dest/ld_data   load result offered; ld_ready = queue not full
//   write_en/write_addr/write_data   registered RF write port
//   pending                    registered scoreboard, bit r = write outstanding
// Build option
//   IRF_WB_PERF_EN  adds perf_ld_deferred[31:0], a saturating count of
//                   cycles in which a queued load was blocked by the ALU.
// ============================================================================
module irf_writeback #(
  parameter int LDQ_DEPTH = 2,
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_dest,
  output logic                 issue_stall,
  input  logic                 alu_valid,
  input  logic [4:0]           alu_dest,
  input  logic [DATA_BITS-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_dest,
  input  logic [DATA_BITS-1:0] ld_data,
  output logic                 write_en,
  output logic [4:0]           write_addr,
  output logic [DATA_BITS-1:0] write_data,
  output logic [31:0]          pending
`ifdef IRF_WB_PERF_EN
  ,
  output logic [31:0]          perf_ld_deferred
`endif
);

  localparam int             PTR_W    = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam logic [PTR_W:0] C_FULL   = (PTR_W + 1)'(LDQ_DEPTH);
  localparam logic [4:0]     C_ZR_REG = 5'd31;

  // Load queue storage and pointers
  logic [4:0]           r_q_dest [LDQ_DEPTH];
  logic [DATA_BITS-1:0] r_q_data [LDQ_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;

  logic                 w_q_empty;
  logic                 w_ld_accept;
  logic                 w_issue_set;
  logic                 w_pop;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_sel_valid;
  logic [4:0]           w_sel_dest;
  logic [DATA_BITS-1:0] w_sel_data;
  logic                 w_sel_wr;
  logic [31:0]          w_pending_nxt;

  always_comb begin
    w_q_empty   = (r_count == '0);
    // Full is judged on the registered count only, so a pop in the same
    // cycle does not reopen the queue until the next cycle.
    ld_ready    = (r_count != C_FULL);
    w_ld_accept = ld_valid && ld_ready;

    issue_stall = issue_valid && pending[issue_dest] && (issue_dest != C_ZR_REG);
    w_issue_set = issue_valid && !issue_stall && (issue_dest != C_ZR_REG);

    // ALU owns the write slot; the queue drains only in ALU-free cycles.
    // A load arriving at an empty queue in such a cycle goes straight through.
    w_pop       = !alu_valid && !w_q_empty;
    w_bypass    = !alu_valid && w_q_empty && w_ld_accept;
    w_push      = w_ld_accept && !w_bypass;
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_dest  = '0;
    w_sel_data  = '0;
    if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_dest  = alu_dest;
      w_sel_data  = alu_data;
    end else if (w_pop) begin
      w_sel_valid = 1'b1;
      w_sel_dest  = r_q_dest[r_rd_ptr];
      w_sel_data  = r_q_data[r_rd_ptr];
    end else if (w_bypass) begin
      w_sel_valid = 1'b1;
      w_sel_dest  = ld_dest;
      w_sel_data  = ld_data;
    end
    // A result for R31 still uses up the slot but produces no write.
    w_sel_wr = w_sel_valid && (w_sel_dest != C_ZR_REG);
  end

  // Clear happens on the edge that raises write_en; a new issue to the same
  // register in that cycle is applied last so the set wins.
  always_comb begin
    w_pending_nxt = pending;
    if (w_sel_wr) begin
      w_pending_nxt[w_sel_dest] = 1'b0;
    end
    if (w_issue_set) begin
      w_pending_nxt[issue_dest] = 1'b1;
    end
  end

  // Queue payload needs no reset; validity is carried by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_dest[r_wr_ptr] <= ld_dest;
      r_q_data[r_wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      pending    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      write_en <= w_sel_wr;
      if (w_sel_wr) begin
        write_addr <= w_sel_dest;
        write_data <= w_sel_data;
      end
      pending <= w_pending_nxt;
    end
  end

`ifdef IRF_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ld_deferred <= '0;
    end else if (!w_q_empty && alu_valid && (perf_ld_deferred != 32'hFFFF_FFFF)) begin
      perf_ld_deferred <= perf_ld_deferred + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_irf_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_irf_writeback
// Purpose  : Self-checking bench for irf_writeback. A vector table drives
//            issue/ALU traffic and checks stall, pending and write_en; hand
//            sequences cover load queueing, back-pressure and reset. Every
//            expected RF write is queued when stimulus is driven and compared
//            in order when write_en is observed.
// Revision : 1.0  initial release
// ============================================================================
module tb_irf_writeback;

  localparam int DATA_BITS = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic [4:0]           issue_dest;
  logic                 issue_stall;
  logic                 alu_valid;
  logic [4:0]           alu_dest;
  logic [DATA_BITS-1:0] alu_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [4:0]           ld_dest;
  logic [DATA_BITS-1:0] ld_data;
  logic                 write_en;
  logic [4:0]           write_addr;
  logic [DATA_BITS-1:0] write_data;
  logic [31:0]          pending;
`ifdef IRF_WB_PERF_EN
  logic [31:0]          perf_ld_deferred;
`endif

  irf_writeback #(.LDQ_DEPTH(2), .DATA_BITS(DATA_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_stall (issue_stall),
    .alu_valid   (alu_valid),
    .alu_dest    (alu_dest),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_dest     (ld_dest),
    .ld_data     (ld_data),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .pending     (pending)
`ifdef IRF_WB_PERF_EN
    ,
    .perf_ld_deferred (perf_ld_deferred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]           addr;
    logic [DATA_BITS-1:0] data;
  } wr_t;

  typedef struct {
    logic                 iv;
    logic [4:0]           id;
    logic                 av;
    logic [4:0]           ad;
    logic [DATA_BITS-1:0] adata;
    logic                 exp_stall;
    logic [31:0]          exp_pend;
    logic                 exp_we;
  } vec_t;

  wr_t  sb[$];
  wr_t  ld_exp[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [DATA_BITS-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_dest = '0;
    alu_valid   = 1'b0; alu_dest   = '0; alu_data = '0;
    ld_valid    = 1'b0; ld_dest    = '0; ld_data  = '0;
  endtask

  // Every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 write_addr, write_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(write_addr), 64'(e.addr));
        check("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        iv  id     av  ad     data              stall  pend          we
    vecs[0]  = '{1'b1, 5'd5,  1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0020, 1'b0};
    vecs[1]  = '{1'b1, 5'd5,  1'b0, 5'd0,  64'h0,    1'b1, 32'h0000_0020, 1'b0};
    vecs[2]  = '{1'b1, 5'd3,  1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0028, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  1'b1, 5'd3,  64'h1234, 1'b0, 32'h0000_0020, 1'b1};
    vecs[4]  = '{1'b1, 5'd31, 1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0020, 1'b0};
    vecs[5]  = '{1'b1, 5'd31, 1'b1, 5'd31, 64'hFF,   1'b0, 32'h0000_0020, 1'b0};
    vecs[6]  = '{1'b1, 5'd6,  1'b1, 5'd6,  64'h66,   1'b0, 32'h0000_0060, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  1'b1, 5'd6,  64'h77,   1'b0, 32'h0000_0020, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  1'b1, 5'd9,  64'h99,   1'b0, 32'h0000_0020, 1'b1};
    vecs[9]  = '{1'b1, 5'd5,  1'b1, 5'd5,  64'h55,   1'b1, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 5'd5,  1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0020, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0020, 1'b0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_write_en",   64'(write_en),   64'd0);
    check("rst_write_addr", 64'(write_addr), 64'd0);
    check("rst_write_data", write_data,      64'd0);
    check("rst_pending",    64'(pending),    64'd0);
    check("rst_ld_ready",   64'(ld_ready),   64'd1);
`ifdef IRF_WB_PERF_EN
    check("rst_perf", 64'(perf_ld_deferred), 64'd0);
`endif
    reset = 1'b0;

    // ---- table: issue / ALU / scoreboard interaction ----
    for (int i = 0; i < 12; i++) begin
      issue_valid = vecs[i].iv;
      issue_dest  = vecs[i].id;
      alu_valid   = vecs[i].av;
      alu_dest    = vecs[i].ad;
      alu_data    = vecs[i].adata;
      if (vecs[i].exp_we) push_wr(vecs[i].ad, vecs[i].adata);
      #1;
      check($sformatf("v%0d_stall", i), 64'(issue_stall), 64'(vecs[i].exp_stall));
      @(negedge clk);
      check($sformatf("v%0d_pending", i),  64'(pending),  64'(vecs[i].exp_pend));
      check($sformatf("v%0d_write_en", i), 64'(write_en), 64'(vecs[i].exp_we));
    end
    idle_inputs();

    // ---- ALU and load in the same cycle: ALU first, load one cycle later ----
    alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 64'h22;
    ld_valid  = 1'b1; ld_dest  = 5'd7; ld_data  = 64'hAA;
    push_wr(5'd2, 64'h22);
    push_wr(5'd7, 64'hAA);
    #1 check("seqA_ld_ready", 64'(ld_ready), 64'd1);
    @(negedge clk);
    idle_inputs();
    check("seqA_c1_addr", 64'(write_addr), 64'd2);
    @(negedge clk);
    check("seqA_c2_we",   64'(write_en),   64'd1);
    check("seqA_c2_addr", 64'(write_addr), 64'd7);
    @(negedge clk);
    check("seqA_drained", 64'(sb.size()), 64'd0);

    // ---- three loads under continuous ALU traffic, then drain ----
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_dest = 5'(10 + 2*c); alu_data = 64'(16'hA000 + c);
      ld_valid  = 1'b1; ld_dest  = 5'(11 + 2*c); ld_data  = 64'(16'hB000 + c);
      push_wr(alu_dest, alu_data);
      #1;
      check($sformatf("seqB_ready_c%0d", c), 64'(ld_ready), (c < 2) ? 64'd1 : 64'd0);
      if (c < 2) begin
        wr_t e;
        e.addr = ld_dest;
        e.data = ld_data;
        ld_exp.push_back(e);
      end
      @(negedge clk);
    end
    // ALU drops; third load still offered while the queue is full.
    alu_valid = 1'b0;
    while (ld_exp.size() > 0) sb.push_back(ld_exp.pop_front());
    push_wr(5'd15, 64'hB002);
    #1 check("seqB_full_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    #1 check("seqB_after_pop_ready", 64'(ld_ready), 64'd1);
    @(negedge clk);
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("seqB_drained", 64'(sb.size()), 64'd0);
`ifdef IRF_WB_PERF_EN
    check("seqB_perf", 64'(perf_ld_deferred), 64'd2);
`endif
    idle_inputs();

    // ---- reset while two loads are queued ----
    issue_valid = 1'b1; issue_dest = 5'd8;
    alu_valid = 1'b1; alu_dest = 5'd20; alu_data = 64'h20;
    ld_valid  = 1'b1; ld_dest  = 5'd22; ld_data  = 64'hC0;
    push_wr(5'd20, 64'h20);
    @(negedge clk);
    issue_valid = 1'b0;
    alu_dest = 5'd21; alu_data = 64'h21;
    ld_dest  = 5'd23; ld_data  = 64'hC1;
    push_wr(5'd21, 64'h21);
    @(negedge clk);
    check("seqC_ready_full", 64'(ld_ready), 64'd0);
    check("seqC_pend_set",   64'(pending[8]), 64'd1);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("seqC_rst_we",      64'(write_en), 64'd0);
    check("seqC_rst_pending", 64'(pending),  64'd0);
    check("seqC_rst_ready",   64'(ld_ready), 64'd1);
    repeat (4) @(negedge clk);
    check("seqC_no_stale_write", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
